// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: issues word-aligned fetches and buffers returned words in a FWFT prefetch FIFO.
// Optional decode-starvation counter is built when FETCH_PERF_EN is defined.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned MEM_LAT    = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fetch_en,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] imem_addr,
  output logic        imem_req,
  input  logic [31:0] imem_rdata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic [31:0] perf_bubble_cnt
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned SW = CW + 1;

  logic [31:0]   pc_q, pc_d;
  logic [CW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] rd_ptr_q, rd_ptr_d;
  logic [31:0]   fifo_instr_q [FIFO_DEPTH];
  logic [31:0]   fifo_instr_d [FIFO_DEPTH];
  logic [31:0]   fifo_pc_q    [FIFO_DEPTH];
  logic [31:0]   fifo_pc_d    [FIFO_DEPTH];

  logic [CW-1:0] occ;
  logic [CW-1:0] inflight;
  logic [SW-1:0] credit_used;
  logic          issue;
  logic          pop;
  logic          land_v;
  logic [31:0]   land_pc;
  logic          unused_redirect_lsbs;

  assign unused_redirect_lsbs = ^redirect_pc[1:0];

  // Credit check counts both buffered and in-flight words so a landing word always has a slot.
  assign occ         = wr_ptr_q - rd_ptr_q;
  assign credit_used = {1'b0, occ} + {1'b0, inflight};
  assign issue       = rst_n & fetch_en & ~redirect_valid & (credit_used < SW'(FIFO_DEPTH));
  assign pop         = out_valid & out_ready;

  assign imem_req  = issue;
  assign imem_addr = pc_q;
  assign out_valid = (wr_ptr_q != rd_ptr_q);
  assign out_instr = fifo_instr_q[rd_ptr_q[AW-1:0]];
  assign out_pc    = fifo_pc_q[rd_ptr_q[AW-1:0]];

  if (MEM_LAT == 1) begin : g_comb_mem
    // Combinational memory: the word is captured at the end of its own issue cycle.
    assign land_v   = issue;
    assign land_pc  = pc_q;
    assign inflight = '0;
  end else begin : g_pipe_mem
    logic [MEM_LAT-2:0] v_q, v_d;
    logic [31:0]        p_q [MEM_LAT-1];
    logic [31:0]        p_d [MEM_LAT-1];

    always_comb begin
      v_d    = '0;
      p_d[0] = pc_q;
      if (!redirect_valid) v_d[0] = issue;
      for (int unsigned k = 1; k < MEM_LAT - 1; k++) begin
        p_d[k] = p_q[k-1];
        if (!redirect_valid) v_d[k] = v_q[k-1];
      end
    end

    always_comb begin
      inflight = '0;
      for (int unsigned k = 0; k < MEM_LAT - 1; k++) begin
        inflight = inflight + CW'(v_q[k]);
      end
    end

    assign land_v  = v_q[MEM_LAT-2];
    assign land_pc = p_q[MEM_LAT-2];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        v_q <= '0;
        for (int unsigned k = 0; k < MEM_LAT - 1; k++) p_q[k] <= '0;
      end else begin
        v_q <= v_d;
        for (int unsigned k = 0; k < MEM_LAT - 1; k++) p_q[k] <= p_d[k];
      end
    end
  end

  // Next-state for pc and FIFO; redirect flushes and drops any word landing this edge.
  always_comb begin
    pc_d         = pc_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    fifo_instr_d = fifo_instr_q;
    fifo_pc_d    = fifo_pc_q;
    if (redirect_valid) begin
      pc_d     = {redirect_pc[31:2], 2'b00};
      rd_ptr_d = wr_ptr_q;
    end else begin
      if (issue) pc_d = pc_q + 32'd4;
      if (land_v) begin
        fifo_instr_d[wr_ptr_q[AW-1:0]] = imem_rdata;
        fifo_pc_d[wr_ptr_q[AW-1:0]]    = land_pc;
        wr_ptr_d                       = wr_ptr_q + CW'(1);
      end
      if (pop) rd_ptr_d = rd_ptr_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q     <= RESET_PC;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        fifo_instr_q[i] <= '0;
        fifo_pc_q[i]    <= '0;
      end
    end else begin
      pc_q     <= pc_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        fifo_instr_q[i] <= fifo_instr_d[i];
        fifo_pc_q[i]    <= fifo_pc_d[i];
      end
    end
  end

`ifdef FETCH_PERF_EN
  logic [31:0] perf_q, perf_d;

  // Saturating count of cycles where decode is ready but starved; redirect does not clear it.
  always_comb begin
    perf_d = perf_q;
    if (out_ready && !out_valid && (perf_q != 32'hFFFF_FFFF)) perf_d = perf_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) perf_q <= '0;
    else        perf_q <= perf_d;
  end

  assign perf_bubble_cnt = perf_q;
`else
  assign perf_bubble_cnt = '0;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: vector table for streaming/redirect/wrap, hand sequences for the rest.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;

  logic        a_fetch_en, a_redirect_valid, a_out_ready;
  logic [31:0] a_redirect_pc, a_addr, a_rdata, a_out_instr, a_out_pc, a_perf;
  logic        a_req, a_out_valid;

  logic        b_fetch_en, b_out_ready;
  logic [31:0] b_addr, b_rdata, b_out_instr, b_out_pc, b_perf_unused;
  logic        b_req, b_out_valid;
  logic [31:0] b_a1, b_a2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'h1000_0000 + {2'b00, a[31:2]};
  endfunction

  instr_fetch_unit #(.RESET_PC(32'h0), .FIFO_DEPTH(4), .MEM_LAT(1)) dut (
    .clk(clk), .rst_n(rst_n), .fetch_en(a_fetch_en), .redirect_valid(a_redirect_valid),
    .redirect_pc(a_redirect_pc), .imem_addr(a_addr), .imem_req(a_req), .imem_rdata(a_rdata),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_instr(a_out_instr),
    .out_pc(a_out_pc), .perf_bubble_cnt(a_perf)
  );

  instr_fetch_unit #(.RESET_PC(32'h0), .FIFO_DEPTH(4), .MEM_LAT(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .fetch_en(b_fetch_en), .redirect_valid(1'b0),
    .redirect_pc(32'h0), .imem_addr(b_addr), .imem_req(b_req), .imem_rdata(b_rdata),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_instr(b_out_instr),
    .out_pc(b_out_pc), .perf_bubble_cnt(b_perf_unused)
  );

  // Memory models: combinational for dut, two-register address pipe for dut3.
  always_comb a_rdata = mem_word(a_addr);
  always @(posedge clk) begin
    b_a1 <= b_addr;
    b_a2 <= b_a1;
  end
  always_comb b_rdata = mem_word(b_a2);

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        fe;
    logic        rdy;
    logic        rv;
    logic [31:0] rpc;
    logic        req;
    logic [31:0] addr;
    logic        v;
    logic [31:0] pc;
    logic [31:0] ins;
  } vec_t;

  vec_t tbl [16];

  initial begin
    int          n_issue;
    logic [31:0] p0;
    logic [31:0] exp_pc;
    int          b_issued, b_pops;

    tbl[0]  = '{1'b1, 1'b1, 1'b0, 32'h0,         1'b1, 32'h0000_0000, 1'b0, 32'h0,         32'h0};
    tbl[1]  = '{1'b1, 1'b1, 1'b0, 32'h0,         1'b1, 32'h0000_0004, 1'b1, 32'h0000_0000, 32'h1000_0000};
    tbl[2]  = '{1'b1, 1'b1, 1'b0, 32'h0,         1'b1, 32'h0000_0008, 1'b1, 32'h0000_0004, 32'h1000_0001};
    tbl[3]  = '{1'b1, 1'b0, 1'b0, 32'h0,         1'b1, 32'h0000_000C, 1'b1, 32'h0000_0008, 32'h1000_0002};
    tbl[4]  = '{1'b1, 1'b0, 1'b0, 32'h0,         1'b1, 32'h0000_0010, 1'b1, 32'h0000_0008, 32'h1000_0002};
    tbl[5]  = '{1'b1, 1'b0, 1'b1, 32'h0000_0043, 1'b0, 32'h0000_0014, 1'b1, 32'h0000_0008, 32'h1000_0002};
    tbl[6]  = '{1'b1, 1'b1, 1'b0, 32'h0,         1'b1, 32'h0000_0040, 1'b0, 32'h0,         32'h0};
    tbl[7]  = '{1'b1, 1'b1, 1'b0, 32'h0,         1'b1, 32'h0000_0044, 1'b1, 32'h0000_0040, 32'h1000_0010};
    tbl[8]  = '{1'b1, 1'b1, 1'b0, 32'h0,         1'b1, 32'h0000_0048, 1'b1, 32'h0000_0044, 32'h1000_0011};
    tbl[9]  = '{1'b1, 1'b1, 1'b1, 32'hFFFF_FFF8, 1'b0, 32'h0000_004C, 1'b1, 32'h0000_0048, 32'h1000_0012};
    tbl[10] = '{1'b1, 1'b1, 1'b0, 32'h0,         1'b1, 32'hFFFF_FFF8, 1'b0, 32'h0,         32'h0};
    tbl[11] = '{1'b1, 1'b1, 1'b0, 32'h0,         1'b1, 32'hFFFF_FFFC, 1'b1, 32'hFFFF_FFF8, 32'h4FFF_FFFE};
    tbl[12] = '{1'b1, 1'b1, 1'b0, 32'h0,         1'b1, 32'h0000_0000, 1'b1, 32'hFFFF_FFFC, 32'h4FFF_FFFF};
    tbl[13] = '{1'b1, 1'b1, 1'b0, 32'h0,         1'b1, 32'h0000_0004, 1'b1, 32'h0000_0000, 32'h1000_0000};
    tbl[14] = '{1'b0, 1'b1, 1'b0, 32'h0,         1'b0, 32'h0000_0008, 1'b1, 32'h0000_0004, 32'h1000_0001};
    tbl[15] = '{1'b0, 1'b1, 1'b0, 32'h0,         1'b0, 32'h0000_0008, 1'b0, 32'h0,         32'h0};

    rst_n            = 1'b0;
    a_fetch_en       = 1'b1;
    a_out_ready      = 1'b1;
    a_redirect_valid = 1'b0;
    a_redirect_pc    = 32'h0;
    b_fetch_en       = 1'b0;
    b_out_ready      = 1'b0;
    repeat (2) next_cycle();

    // Reset state with fetch_en/out_ready already high.
    @(negedge clk);
    chk("reset imem_req", 32'(a_req), 32'd0);
    chk("reset imem_addr", a_addr, 32'h0);
    chk("reset out_valid", 32'(a_out_valid), 32'd0);
    chk("reset out_instr", a_out_instr, 32'h0);
    chk("reset out_pc", a_out_pc, 32'h0);
    chk("reset perf", a_perf, 32'h0);
    next_cycle();
    rst_n = 1'b1;

    // Streaming, redirect with 3 buffered entries, redirect with pop, and address wrap.
    for (int i = 0; i < 16; i++) begin
      a_fetch_en       = tbl[i].fe;
      a_out_ready      = tbl[i].rdy;
      a_redirect_valid = tbl[i].rv;
      a_redirect_pc    = tbl[i].rpc;
      @(negedge clk);
      chk($sformatf("vec%0d imem_req", i), 32'(a_req), 32'(tbl[i].req));
      chk($sformatf("vec%0d imem_addr", i), a_addr, tbl[i].addr);
      chk($sformatf("vec%0d out_valid", i), 32'(a_out_valid), 32'(tbl[i].v));
      if (tbl[i].v) begin
        chk($sformatf("vec%0d out_pc", i), a_out_pc, tbl[i].pc);
        chk($sformatf("vec%0d out_instr", i), a_out_instr, tbl[i].ins);
      end
      next_cycle();
    end
    a_redirect_valid = 1'b0;

    // Bubble counter over 5 starved cycles with an empty FIFO.
    a_fetch_en  = 1'b0;
    a_out_ready = 1'b1;
    @(negedge clk);
    p0 = a_perf;
    chk("perf start out_valid", 32'(a_out_valid), 32'd0);
    repeat (5) begin
      next_cycle();
      @(negedge clk);
    end
`ifdef FETCH_PERF_EN
    chk("perf delta", a_perf, p0 + 32'd5);
`else
    chk("perf start tied", p0, 32'h0);
    chk("perf end tied", a_perf, 32'h0);
`endif

    // Mid-operation reset discards buffered words immediately.
    next_cycle();
    a_fetch_en  = 1'b1;
    a_out_ready = 1'b0;
    repeat (2) next_cycle();
    @(negedge clk);
    chk("prefill out_valid", 32'(a_out_valid), 32'd1);
    chk("prefill out_pc", a_out_pc, 32'h8);
    next_cycle();
    rst_n = 1'b0;
    #1;
    chk("midreset out_valid", 32'(a_out_valid), 32'd0);
    chk("midreset imem_req", 32'(a_req), 32'd0);
    chk("midreset imem_addr", a_addr, 32'h0);
    chk("midreset out_pc", a_out_pc, 32'h0);

    // Backpressure from reset: exactly 4 issues, head pinned at pc 0.
    next_cycle();
    rst_n   = 1'b1;
    n_issue = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (a_req) n_issue++;
      if (k >= 1) begin
        chk($sformatf("bp%0d out_valid", k), 32'(a_out_valid), 32'd1);
        chk($sformatf("bp%0d out_pc", k), a_out_pc, 32'h0);
      end
      if (k >= 4) chk($sformatf("bp%0d imem_req", k), 32'(a_req), 32'd0);
      next_cycle();
    end
    chk("bp issue count", 32'(n_issue), 32'd4);
    chk("bp imem_addr", a_addr, 32'h10);
    a_out_ready = 1'b1;
    a_fetch_en  = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("drain%0d out_valid", k), 32'(a_out_valid), 32'd1);
      chk($sformatf("drain%0d out_pc", k), a_out_pc, 32'(4 * k));
      chk($sformatf("drain%0d out_instr", k), a_out_instr, mem_word(32'(4 * k)));
      next_cycle();
    end
    @(negedge clk);
    chk("drain empty", 32'(a_out_valid), 32'd0);

    // MEM_LAT=3 scoreboard with toggling fetch_en and random out_ready.
    next_cycle();
    rst_n = 1'b0;
    next_cycle();
    rst_n    = 1'b1;
    exp_pc   = 32'h0;
    b_issued = 0;
    b_pops   = 0;
    for (int c = 0; c < 320; c++) begin
      b_fetch_en  = (c < 300) ? (((c / 2) % 2) == 0) : 1'b0;
      b_out_ready = (c < 300) ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      if (b_req) chk($sformatf("lat3 c%0d credit", c), 32'((b_issued - b_pops) < 4), 32'd1);
      if (b_out_valid && b_out_ready) begin
        chk($sformatf("lat3 c%0d out_pc", c), b_out_pc, exp_pc);
        chk($sformatf("lat3 c%0d out_instr", c), b_out_instr, mem_word(exp_pc));
        exp_pc = exp_pc + 32'd4;
        b_pops++;
      end
      if (b_req) b_issued++;
      next_cycle();
    end
    chk("lat3 issued==popped", 32'(b_issued), 32'(b_pops));
    chk("lat3 stream progressed", 32'(b_pops > 20), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
